// File: rtl/bpsk_pkg.sv
// bpsk_pkg: constants and FSM state type shared by the BPSK framer and deframer
package bpsk_pkg;

    localparam int          BYTE_W        = 8;
    localparam int          SYNC_W        = 16;
    localparam int          BIT_CNT_W     = 8;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage

// File: rtl/bpsk_bit_timer.sv
// bpsk_bit_timer: free-running bit-period divider, parked at zero while not running
module bpsk_bit_timer #(
    parameter int BIT_PERIOD = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

    logic [W-1:0] cnt_q;

    assign bit_tick = run && (cnt_q == W'(BIT_PERIOD - 1));

    // count 0..BIT_PERIOD-1 while running, otherwise hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= (run && !bit_tick) ? cnt_q + 1'b1 : '0;
    end

endmodule

// File: rtl/bpsk_tx_framer.sv
// bpsk_tx_framer: wraps payload bytes into preamble + sync + payload + idle-gap bit frames
module bpsk_tx_framer
    import bpsk_pkg::*;
#(
    parameter int          BIT_PERIOD    = 20,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEF,
    parameter int          GAP_BITS      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bit_data_out,
    output logic              bit_data_out_en,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0]     hold_q, hold_d, shift_q, shift_d;
    logic                  hold_full_q, hold_full_d;
    logic                  hold_last_q, hold_last_d;
    logic                  shift_last_q, shift_last_d;
    logic                  closed_q, closed_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underrun_q, underrun_d;
    logic                  bit_tick, run, accept, load;

    assign run             = (state_q != ST_IDLE);
    assign busy            = run;
    assign s_ready         = !hold_full_q && !closed_q;
    assign accept          = s_valid && s_ready;
    assign frame_done      = frame_done_q;
    assign underrun        = underrun_q;
    assign bit_data_out_en = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) || (state_q == ST_PAYLOAD);
    assign bit_data_out    = (state_q == ST_PREAMBLE) ? !cnt_q[0] :
                             (state_q == ST_SYNC)     ? SYNC_WORD[4'(SYNC_W - 1) - cnt_q[3:0]] :
                             (state_q == ST_PAYLOAD) && shift_q[BYTE_W-1];

    bpsk_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .bit_tick (bit_tick)
    );

    // frame sequencing; closed_q blocks intake once the frame is ended (s_last or underrun)
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        hold_last_d  = hold_last_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        closed_d     = closed_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = accept ? ST_PREAMBLE : ST_IDLE;
            end
            ST_PREAMBLE: if (bit_tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_CNT_W'(PREAMBLE_BITS - 1)) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: if (bit_tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_CNT_W'(SYNC_W - 1)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_PAYLOAD: if (bit_tick) begin
                cnt_d   = cnt_q + 1'b1;
                shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                if (cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                    cnt_d = '0;
                    if (shift_last_q) begin
                        state_d = ST_GAP;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d    = ST_GAP;
                        underrun_d = 1'b1;
                        closed_d   = 1'b1;
                    end
                end
            end
            ST_GAP: if (bit_tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_CNT_W'(GAP_BITS - 1)) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                    closed_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            shift_d      = hold_q;
            shift_last_d = hold_last_q;
            hold_full_d  = 1'b0;
        end
        if (accept) begin
            hold_d      = s_data;
            hold_last_d = s_last;
            hold_full_d = 1'b1;
            closed_d    = closed_d || s_last;
        end
    end

    // state, datapath and pulse registers; reset aborts any frame silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            shift_q      <= '0;
            shift_last_q <= 1'b0;
            closed_q     <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            hold_last_q  <= hold_last_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            closed_q     <= closed_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: doc/bpsk_tx_framer.md
BPSK_TX_FRAMER -- requirements
Module: bpsk_tx_framer

Interface
REQ-001 The block SHALL have parameter BIT_PERIOD, default 20, meaning clocks per transmitted bit (minimum 2).
REQ-002 The block SHALL have parameter PREAMBLE_BITS, default 16, meaning the count of alternating preamble bits (even, minimum 2).
REQ-003 The block SHALL have parameter SYNC_WORD, default 16'hD391, meaning the 16-bit frame sync pattern.
REQ-004 The block SHALL have parameter GAP_BITS, default 8, meaning the number of idle bit periods after each frame.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port s_data, input, 8 bits: payload byte.
REQ-008 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 The block SHALL have port s_last, input, 1 bit: the byte is the last byte of its frame.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the byte is accepted when s_valid and s_ready are both high.
REQ-011 The block SHALL have port bit_data_out, output, 1 bit: serial bit to the modem's bit_data_in.
REQ-012 The block SHALL have port bit_data_out_en, output, 1 bit: serial bit valid, to the modem's bit_data_in_en.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on GAP exit.
REQ-015 The block SHALL have port underrun, output, 1 bit: one-cycle pulse on payload starvation.

Function
REQ-016 The FSM SHALL have the states IDLE, PREAMBLE, SYNC, PAYLOAD and GAP.
REQ-017 A bit timer SHALL count 0..BIT_PERIOD-1, hold at 0 in IDLE, and assert bit_tick when the count is BIT_PERIOD-1.
REQ-018 A bit counter SHALL advance on bit_tick, and every state change other than IDLE exit SHALL occur on bit_tick.
REQ-019 A one-byte holding register SHALL buffer input, and s_ready SHALL equal "hold empty AND no s_last byte accepted in the current frame".
REQ-020 In IDLE, acceptance of a byte SHALL store it in the holding register, and the next cycle SHALL be PREAMBLE bit 0.
REQ-021 PREAMBLE SHALL emit PREAMBLE_BITS bits alternating 1,0,1,0..., starting with 1.
REQ-022 SYNC SHALL emit SYNC_WORD as 16 bits, MSB first.
REQ-023 On PAYLOAD entry, and at each later byte boundary, the holding register SHALL load into the shift register, and the hold SHALL be freed in that same cycle.
REQ-024 PAYLOAD SHALL emit each byte MSB first, 8 bit periods per byte.
REQ-025 Each emitted bit SHALL be held stable for exactly BIT_PERIOD cycles, with bit_data_out_en=1 throughout PREAMBLE, SYNC and PAYLOAD.
REQ-026 At the end of a byte carrying s_last, the FSM SHALL go to GAP.
REQ-027 At a byte boundary where the hold is empty and s_last has not been seen, the block SHALL pulse underrun and go to GAP with the frame truncated.
REQ-028 During an underrun, bytes SHALL NOT be accepted until IDLE.
REQ-029 GAP SHALL last GAP_BITS bit periods with bit_data_out=0 and bit_data_out_en=0, then pulse frame_done and go to IDLE.
REQ-030 s_valid with s_ready=0 SHALL be ignored, and no byte SHALL be dropped or duplicated.
REQ-031 When a byte is accepted in the same cycle as a hold-to-shift load, the accepted byte SHALL land in the freed hold.
REQ-032 A single-byte frame (s_last on the first byte) SHALL be legal.

Reset
REQ-033 While rst_n=0, the block SHALL force state=IDLE, counters=0, hold empty, s_ready=1, bit_data_out=0, bit_data_out_en=0, busy=0, frame_done=0 and underrun=0.
REQ-034 Reset assertion mid-frame SHALL abort the frame immediately with no pulses, and after release the block SHALL wait in IDLE for a new byte.

Structure
REQ-035 Package bpsk_pkg SHALL hold the state enum, the SYNC_WORD default, the byte width and the bit-counter width, shared with the receive-side deframer.
REQ-036 The bit timer SHALL be a sub-module bpsk_bit_timer with inputs clk, rst_n, run and output bit_tick.

Verification
REQ-037 The bench SHALL send 1 byte 8'hA5 with s_last, using defaults -> en high for 40 bit periods (800 cycles): 1010...(16), D391 MSB first, then 10100101; then 8 gap periods with en=0; frame_done pulses exactly 960 cycles after the PREAMBLE start.
REQ-038 The bench SHALL send 3 bytes 8'h01,8'h80,8'hFF back-to-back with s_valid held high -> s_ready stalls correctly, payload bits 00000001 10000000 11111111, no underrun.
REQ-039 The bench SHALL send 2 bytes with no s_last and s_valid then dropped -> underrun pulses at the end of byte 2, GAP follows, and no frame_done-less hang occurs.
REQ-040 The bench SHALL pulse rst_n low during SYNC bit 5 -> outputs take reset values that same cycle, and a following 1-byte frame is correct from its preamble.
REQ-041 With BIT_PERIOD=2 and PREAMBLE_BITS=2, the bench SHALL send 1 byte 8'h3C -> every bit is held exactly 2 cycles and the total en-high time is 52 cycles.
REQ-042 The bench SHALL feed bit_data_out/bit_data_out_en into bpsk_modem_top in loopback -> recovered bits match the transmitted frame after modem latency.
